// File: rtl/mips_mc_ctrl.sv
`default_nettype none
// mips_mc_ctrl -- multi-cycle MIPS control unit: FSM, PC/IR, retire counter, busy timeout.
// Revision 1.0
module mips_mc_ctrl #(
  parameter int            AW      = 32,
  parameter logic [AW-1:0] PC_INIT = '0,
  parameter int            TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          imem_busy,
  input  logic          dmem_busy,
  input  logic [31:0]   instr,
  input  logic [31:0]   rs_data,
  input  logic          alu_zero,
  output logic [AW-1:0] pc,
  output logic [2:0]    state,
  output logic          ab_we,
  output logic          alu_src,
  output logic          reg_dst,
  output logic          reg_we,
  output logic          mem_to_reg,
  output logic          dm_enable,
  output logic          dm_rd_wr,
  output logic          illegal,
  output logic          timeout,
  output logic [31:0]   instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam int            CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J};
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   ir_q, ir_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [31:0]   instr_count_q, instr_count_d;
  logic [CW-1:0] busy_q, busy_d;
  logic          ab_we_q, alu_src_q, reg_dst_q, reg_we_q, mem_to_reg_q;
  logic          dm_enable_q, dm_rd_wr_q, illegal_q, timeout_q;

  // Decode of the instruction currently held in IR.
  logic [5:0] op_w, fn_w;
  logic       is_rtype, is_jr, is_alu, is_addiu, is_lw, is_sw, is_beq, is_bne, is_j, is_ill;

  assign op_w     = ir_q[31:26];
  assign fn_w     = ir_q[5:0];
  assign is_rtype = (op_w == OP_RTYPE);
  assign is_jr    = is_rtype && (fn_w == FN_JR);
  assign is_alu   = is_rtype && !is_jr;
  assign is_addiu = (op_w == OP_ADDIU);
  assign is_lw    = (op_w == OP_LW);
  assign is_sw    = (op_w == OP_SW);
  assign is_beq   = (op_w == OP_BEQ);
  assign is_bne   = (op_w == OP_BNE);
  assign is_j     = (op_w == OP_J);
  assign is_ill   = !op_legal(op_w);

  // Controls are registered, so they are derived from the next state and next IR.
  logic [5:0] nop_w;
  logic       n_rtype, n_addiu, n_lw, n_sw, n_ill;

  assign nop_w   = ir_d[31:26];
  assign n_rtype = (nop_w == OP_RTYPE);
  assign n_addiu = (nop_w == OP_ADDIU);
  assign n_lw    = (nop_w == OP_LW);
  assign n_sw    = (nop_w == OP_SW);
  assign n_ill   = !op_legal(nop_w);

  logic stall;

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    stall   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_busy) begin
          stall = 1'b1;
        end else begin
          state_d = S_DECODE;
          ir_d    = instr;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_lw || is_sw)          state_d = S_MEM;
        else if (is_alu || is_addiu) state_d = S_WB;
        else                         state_d = S_FETCH;
      end
      S_MEM: begin
        if (dmem_busy) stall = 1'b1;
        else           state_d = is_lw ? S_WB : S_FETCH;
      end
      S_WB:    state_d = S_FETCH;
      default: state_d = S_FETCH;
    endcase
  end

  logic          retire, br_taken;
  logic [AW-1:0] pc_plus4, br_off, j_tgt;

  assign retire   = (state_q != S_FETCH) && (state_d == S_FETCH);
  assign pc_plus4 = pc_q + AW'(4);
  assign br_off   = {{(AW-18){ir_q[15]}}, ir_q[15:0], 2'b00};
  assign br_taken = (is_beq && alu_zero) || (is_bne && !alu_zero);

  generate
    if (AW > 28) begin : g_jtgt_region
      assign j_tgt = {pc_plus4[AW-1:28], ir_q[25:0], 2'b00};
    end else begin : g_jtgt_flat
      assign j_tgt = {ir_q[25:0], 2'b00};
    end
  endgenerate

  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      if (br_taken)   pc_d = pc_plus4 + br_off;
      else if (is_j)  pc_d = j_tgt;
      else if (is_jr) pc_d = rs_data[AW-1:0];
      else            pc_d = pc_plus4;
    end
  end

  assign instr_count_d = (retire && !is_ill) ? instr_count_q + 32'd1 : instr_count_q;

  // The stall counter restarts after each timeout so the pulse repeats while stuck.
  logic [CW-1:0] busy_inc;
  logic          to_hit;

  assign busy_inc = busy_q + 1'b1;
  assign to_hit   = (TIMEOUT > 0) && stall && (busy_inc == TO_LIM);
  assign busy_d   = (!stall || to_hit) ? '0 : busy_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_FETCH;
      pc_q          <= PC_INIT;
      ir_q          <= '0;
      instr_count_q <= '0;
      busy_q        <= '0;
      ab_we_q       <= 1'b0;
      alu_src_q     <= 1'b0;
      reg_dst_q     <= 1'b0;
      reg_we_q      <= 1'b0;
      mem_to_reg_q  <= 1'b0;
      dm_enable_q   <= 1'b0;
      dm_rd_wr_q    <= 1'b1;
      illegal_q     <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      ir_q          <= ir_d;
      instr_count_q <= instr_count_d;
      busy_q        <= busy_d;
      ab_we_q       <= (state_d == S_DECODE);
      alu_src_q     <= (state_d inside {S_EXEC, S_MEM, S_WB}) && (n_addiu || n_lw || n_sw);
      reg_dst_q     <= (state_d != S_FETCH) && n_rtype;
      reg_we_q      <= (state_d == S_WB);
      mem_to_reg_q  <= (state_d == S_WB) && n_lw;
      dm_enable_q   <= (state_d == S_MEM);
      dm_rd_wr_q    <= !((state_d == S_MEM) && n_sw);
      illegal_q     <= (state_d == S_EXEC) && n_ill;
      timeout_q     <= to_hit;
    end
  end

  assign pc          = pc_q;
  assign state       = state_q;
  assign ab_we       = ab_we_q;
  assign alu_src     = alu_src_q;
  assign reg_dst     = reg_dst_q;
  assign reg_we      = reg_we_q;
  assign mem_to_reg  = mem_to_reg_q;
  assign dm_enable   = dm_enable_q;
  assign dm_rd_wr    = dm_rd_wr_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_ctrl.sv
`default_nettype none
// tb_mips_mc_ctrl -- directed and randomized check of mips_mc_ctrl against an instruction-level model.
module tb_mips_mc_ctrl;

  localparam int          TO      = 4;
  localparam logic [31:0] PC_RST  = 32'h0;

  logic        clk = 1'b0;
  logic        reset, imem_busy, dmem_busy, alu_zero;
  logic [31:0] instr, rs_data;
  logic [31:0] pc;
  logic [2:0]  state;
  logic        ab_we, alu_src, reg_dst, reg_we, mem_to_reg, dm_enable, dm_rd_wr;
  logic        illegal, timeout;
  logic [31:0] instr_count;

  always #5 clk = ~clk;

  mips_mc_ctrl #(.AW(32), .PC_INIT(PC_RST), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .instr(instr), .rs_data(rs_data), .alu_zero(alu_zero),
    .pc(pc), .state(state), .ab_we(ab_we), .alu_src(alu_src), .reg_dst(reg_dst),
    .reg_we(reg_we), .mem_to_reg(mem_to_reg), .dm_enable(dm_enable), .dm_rd_wr(dm_rd_wr),
    .illegal(illegal), .timeout(timeout), .instr_count(instr_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- instruction-level reference model ----------------
  typedef enum int {K_ALU, K_ADDIU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_ILL} kind_e;

  function automatic kind_e kind_of(input logic [31:0] w);
    kind_e k;
    case (w[31:26])
      6'h00:   k = (w[5:0] == 6'h08) ? K_JR : K_ALU;
      6'h09:   k = K_ADDIU;
      6'h23:   k = K_LW;
      6'h2B:   k = K_SW;
      6'h04:   k = K_BEQ;
      6'h05:   k = K_BNE;
      6'h02:   k = K_J;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  // Sequence of states each instruction class walks through; -1 marks the end.
  function automatic int route(input kind_e k, input int i);
    int seq[5];
    case (k)
      K_LW:           seq = '{0, 1, 2, 3, 4};
      K_SW:           seq = '{0, 1, 2, 3, -1};
      K_ALU, K_ADDIU: seq = '{0, 1, 2, 4, -1};
      default:        seq = '{0, 1, 2, -1, -1};
    endcase
    return (i < 5) ? seq[i] : -1;
  endfunction

  function automatic logic [31:0] retire_pc(input kind_e k, input logic [31:0] cur,
                                            input logic [31:0] ir, input logic [31:0] rs,
                                            input logic z);
    logic [31:0] seq_pc;
    int          off;
    seq_pc = cur + 32'd4;
    off    = int'($signed(ir[15:0])) * 4;
    case (k)
      K_BEQ:   return z  ? seq_pc + off : seq_pc;
      K_BNE:   return !z ? seq_pc + off : seq_pc;
      K_J:     return {seq_pc[31:28], ir[25:0], 2'b00};
      K_JR:    return rs;
      default: return seq_pc;
    endcase
  endfunction

  int          m_state, m_step, m_busy, m_nxt;
  logic [31:0] m_pc, m_ir, m_cnt;
  bit          m_to, m_stalled;
  bit          m_valid = 1'b0;
  kind_e       m_k, c_k;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_step = 0; m_busy = 0;
      m_pc = PC_RST; m_ir = '0; m_cnt = '0; m_to = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_k       = kind_of(m_ir);
      m_to      = 1'b0;
      m_stalled = (m_state == 0 && imem_busy) || (m_state == 3 && dmem_busy);
      if (m_stalled) begin
        m_busy++;
        if (m_busy == TO) begin
          m_to   = 1'b1;
          m_busy = 0;
        end
      end else begin
        m_busy = 0;
        if (m_state == 0) begin
          m_ir = instr; m_step = 1; m_state = 1;
        end else begin
          m_nxt = route(m_k, m_step + 1);
          if (m_nxt < 0) begin
            m_pc = retire_pc(m_k, m_pc, m_ir, rs_data, alu_zero);
            if (m_k != K_ILL) m_cnt++;
            m_step = 0; m_state = 0;
          end else begin
            m_step++;
            m_state = m_nxt;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      c_k = kind_of(m_ir);
      chk("m_state", {29'd0, state}, m_state);
      chk("m_pc", pc, m_pc);
      chk("m_instr_count", instr_count, m_cnt);
      chk("m_ab_we", ab_we, m_state == 1);
      chk("m_alu_src", alu_src, m_state >= 2 && (c_k == K_ADDIU || c_k == K_LW || c_k == K_SW));
      chk("m_reg_dst", reg_dst, m_state != 0 && m_ir[31:26] == 6'h00);
      chk("m_reg_we", reg_we, m_state == 4);
      chk("m_mem_to_reg", mem_to_reg, m_state == 4 && c_k == K_LW);
      chk("m_dm_enable", dm_enable, m_state == 3);
      chk("m_dm_rd_wr", dm_rd_wr, !(m_state == 3 && c_k == K_SW));
      chk("m_illegal", illegal, m_state == 2 && c_k == K_ILL);
      chk("m_timeout", timeout, m_to);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run3(input logic [31:0] w);
    instr = w;
    repeat (3) tick();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 9))
      0:       return {6'h00, r[25:6], 6'h21};
      1:       return {6'h00, r[25:0]};
      2:       return {6'h00, r[25:6], 6'h08};
      3:       return {6'h09, r[25:0]};
      4:       return {6'h23, r[25:0]};
      5:       return {6'h2B, r[25:0]};
      6:       return {6'h04, r[25:0]};
      7:       return {6'h05, r[25:0]};
      8:       return {6'h02, r[25:0]};
      default: return r;
    endcase
  endfunction

  int lvl;

  initial begin
    reset = 1'b1; imem_busy = 1'b0; dmem_busy = 1'b0;
    instr = '0; rs_data = '0; alu_zero = 1'b0;
    tick(); tick();
    chk("rst_state", {29'd0, state}, 32'd0);
    chk("rst_pc", pc, PC_RST);
    chk("rst_count", instr_count, 32'd0);
    chk("rst_dm_rd_wr", dm_rd_wr, 1'b1);
    chk("rst_reg_dst", reg_dst, 1'b0);
    reset = 1'b0;

    // addiu $t0,$0,5
    instr = 32'h2408_0005;
    tick(); chk("addiu_decode", {29'd0, state}, 32'd1); chk("addiu_ab_we", ab_we, 1'b1);
    instr = $urandom;
    tick(); chk("addiu_exec", {29'd0, state}, 32'd2);
    tick(); chk("addiu_wb", {29'd0, state}, 32'd4); chk("addiu_reg_we", reg_we, 1'b1);
    chk("addiu_reg_dst", reg_dst, 1'b0); chk("addiu_alu_src", alu_src, 1'b1);
    tick(); chk("addiu_fetch", {29'd0, state}, 32'd0);
    chk("addiu_pc", pc, 32'h4); chk("addiu_count", instr_count, 32'd1);

    // sw with three stalled MEM cycles; busy during EXEC is ignored
    instr = 32'hAD09_0008;
    tick();
    dmem_busy = 1'b1;
    tick(); chk("sw_exec", {29'd0, state}, 32'd2);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("sw_mem_state", {29'd0, state}, 32'd3);
      chk("sw_mem_rd_wr", dm_rd_wr, 1'b0);
      if (i == 3) dmem_busy = 1'b0;
      tick();
    end
    chk("sw_fetch", {29'd0, state}, 32'd0);
    chk("sw_pc", pc, 32'h8); chk("sw_count", instr_count, 32'd2);

    // branches at pc 0x10
    run3(32'h0800_0004); chk("j_to_10", pc, 32'h10);
    alu_zero = 1'b1; run3(32'h1000_FFFC); chk("beq_taken", pc, 32'h04);
    run3(32'h0800_0004);
    alu_zero = 1'b0; run3(32'h1000_FFFC); chk("beq_untaken", pc, 32'h14);
    chk("br_count", instr_count, 32'd6);

    rs_data = 32'h0000_0100;
    run3(32'h0100_0008); chk("jr_pc", pc, 32'h100); chk("jr_count", instr_count, 32'd7);

    // illegal opcode 0x3F
    instr = 32'hFC00_0000;
    tick(); chk("ill_decode_quiet", illegal, 1'b0);
    tick(); chk("ill_pulse", illegal, 1'b1);
    tick(); chk("ill_clear", illegal, 1'b0);
    chk("ill_pc", pc, 32'h104); chk("ill_count", instr_count, 32'd7);

    // fetch stall with TIMEOUT = 4, then reset mid-stall
    imem_busy = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      chk("to_pulse", timeout, (c == 5 || c == 9));
      chk("to_state", {29'd0, state}, 32'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    chk("rst_stall_state", {29'd0, state}, 32'd0);
    chk("rst_stall_pc", pc, PC_RST);
    chk("rst_stall_count", instr_count, 32'd0);
    reset = 1'b0; imem_busy = 1'b0;
    run3(32'h0800_0040); chk("j_to_100", pc, 32'h100);

    // randomized traffic, model-checked every cycle
    lvl = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) lvl = $urandom_range(0, 9);
      imem_busy = ($urandom_range(0, 9) < lvl);
      dmem_busy = ($urandom_range(0, 9) < lvl);
      alu_zero  = $urandom_range(0, 1);
      rs_data   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      instr     = rand_instr();
      reset     = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0;
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
